if_fetch: RTL

Instruction-fetch stage: owns the program counter, drives the instruction-memory request/acknowledge handshake, and presents `if_pc`/`if_inst` to the IF/ID pipeline register. It obeys the pipeline stall vector, follows ID-stage branch redirects and exception flushes, and raises a stall request to the pipeline controller while an instruction fetch is outstanding.

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/fetch_pc_sel.sv | 27 ++
 rtl/if_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W   = 32;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned STALL_W       = 6;
    localparam int unsigned FETCH_STATE_W = 2;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;
    typedef logic [STALL_W-1:0]     stall_t;

    // Value of a stall bit: STOP holds the stage, NOSTOP lets it run.
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Encodes as a NOP.
    localparam inst_t ZERO_WORD = '0;

    typedef enum logic [FETCH_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: flush address, then pending branch, then live branch, then pc+4.
module fetch_pc_sel
    import if_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pend_flag,
    input  logic [31:0] pend_target,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic [31:0] next_pc
);

    // Priority select; the increment wraps naturally at 32 bits.
    always_comb begin
        next_pc = pc + 32'd4;
        if (flush) begin
            next_pc = new_pc;
        end else if (pend_flag) begin
            next_pc = pend_target;
        end else if (branch_flag) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, imem handshake, stall/branch/flush handling.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned fetch raises exc_adel
// instead of issuing a request).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if,
    output logic        exc_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_flag_q, pend_flag_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  inst_buf_q, inst_buf_d;
    logic [31:0]  drain_target_q, drain_target_d;
    logic [31:0]  next_pc;
    logic         advance;
    logic         misaligned;

    // Only stall bit 0 concerns this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    fetch_pc_sel u_pc_sel (
        .pc            (pc_q),
        .pend_flag     (pend_flag_q),
        .pend_target   (pend_target_q),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .next_pc       (next_pc)
    );

    // Alignment check on the current PC (compiled out by default).
    always_comb begin
        misaligned = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned = (state_q == S_FETCH) && (pc_q[1:0] != 2'b00);
`endif
    end

    // State register and fetch bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            pend_flag_q    <= 1'b0;
            pend_target_q  <= '0;
            inst_buf_q     <= ZERO_WORD;
            drain_target_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_flag_q    <= pend_flag_d;
            pend_target_q  <= pend_target_d;
            inst_buf_q     <= inst_buf_d;
            drain_target_q <= drain_target_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_flag_d    = pend_flag_q;
        pend_target_d  = pend_target_q;
        inst_buf_d     = inst_buf_q;
        drain_target_d = drain_target_q;
        advance        = 1'b0;
        imem_req       = 1'b0;
        imem_addr      = '0;
        if_pc          = '0;
        if_inst        = ZERO_WORD;
        stallreq_if    = 1'b0;
        exc_adel       = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if_pc = pc_q;
                if (misaligned) begin
                    // No request; PC keeps moving so the exception path can flush.
                    exc_adel = 1'b1;
                    advance  = (stall[0] == NOSTOP);
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = pc_q;
                    if (imem_ack) begin
                        if_inst = imem_rdata;
                        if (stall[0] == NOSTOP) begin
                            advance = 1'b1;
                        end else begin
                            inst_buf_d = imem_rdata;
                            state_d    = S_HOLD;
                        end
                    end else begin
                        stallreq_if = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if_pc   = pc_q;
                if_inst = inst_buf_q;
                if (stall[0] == NOSTOP) begin
                    advance = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Keep the stale request stable until memory answers it.
                if_pc       = pc_q;
                imem_req    = 1'b1;
                imem_addr   = pc_q;
                stallreq_if = 1'b1;
                if (imem_ack) begin
                    pc_d    = drain_target_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            pc_d        = next_pc;
            pend_flag_d = 1'b0;
        end else if (branch_flag) begin
            pend_flag_d   = 1'b1;
            pend_target_d = branch_target;
        end

        // Flush overrides everything; an unanswered request must drain first.
        if (flush) begin
            pend_flag_d = 1'b0;
            if_inst     = ZERO_WORD;
            if ((state_q == S_FETCH && !imem_ack && !misaligned) ||
                (state_q == S_DRAIN && !imem_ack)) begin
                drain_target_d = next_pc;
                state_d        = S_DRAIN;
            end else begin
                pc_d    = next_pc;
                state_d = S_FETCH;
            end
        end
    end

endmodule
